// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the instruction cache: FSM encoding, block geometry,
// CPU address field positions and a saturating counter helper.
package instruction_cache_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } icache_state_e;

    localparam int BLOCK_BYTES   = 16;
    localparam int BLOCK_W       = BLOCK_BYTES * 8;
    localparam int WORD_W        = 32;
    localparam int WORD_OFFSET_W = 2;

    // Byte address layout: [1:0] byte, [3:2] word offset, index and tag above.
    localparam int CPU_ADDR_W  = 10;
    localparam int OFFSET_LSB  = 2;
    localparam int INDEX_LSB   = OFFSET_LSB + WORD_OFFSET_W;

    localparam int STAT_W = 16;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
        return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/icache_word_select.sv
// Picks one 32-bit word out of a 16-byte cache block by word offset.
// Pure combinational; shared with the data cache.
module icache_word_select
    import instruction_cache_pkg::*;
(
    input  logic [BLOCK_W-1:0]       block_i,
    input  logic [WORD_OFFSET_W-1:0] offset_i,
    output logic [WORD_W-1:0]        word_o
);

    always_comb begin
        word_o = block_i[WORD_W-1:0];
        case (offset_i)
            2'd0: word_o = block_i[31:0];
            2'd1: word_o = block_i[63:32];
            2'd2: word_o = block_i[95:64];
            2'd3: word_o = block_i[127:96];
            default: word_o = block_i[31:0];
        endcase
    end

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with block-fill from instruction memory.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES    = 8,
    parameter int BLOCK_ADDR_W = 6
)(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_read,
    input  logic [CPU_ADDR_W-1:0]   cpu_address,
    output logic [WORD_W-1:0]       cpu_instruction,
    output logic                    cpu_busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [BLOCK_W-1:0]      mem_readdata,
    input  logic                    mem_busywait
`ifdef ICACHE_STATS_EN
    ,
    output logic [STAT_W-1:0]       hit_count,
    output logic [STAT_W-1:0]       miss_count
`endif
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = BLOCK_ADDR_W - INDEX_W;
    localparam int TAG_LSB = INDEX_LSB + INDEX_W;

    icache_state_e state_q, state_d;

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [BLOCK_W-1:0]   data_q [NUM_LINES];
    logic [BLOCK_W-1:0]   line_buf_q;

    logic [INDEX_W-1:0]   req_index_q;
    logic [TAG_W-1:0]     req_tag_q;

    logic [WORD_OFFSET_W-1:0] cpu_offset;
    logic [INDEX_W-1:0]       cpu_index;
    logic [TAG_W-1:0]         cpu_tag;
    logic                     hit;
    logic [WORD_W-1:0]        selected_word;

    logic start_fill;
    logic capture_block;
    logic write_line;

    // Byte-within-word bits never matter for word fetches.
    logic unused_byte_bits;
    assign unused_byte_bits = ^cpu_address[OFFSET_LSB-1:0];

    assign cpu_offset = cpu_address[OFFSET_LSB +: WORD_OFFSET_W];
    assign cpu_index  = cpu_address[INDEX_LSB +: INDEX_W];
    assign cpu_tag    = cpu_address[TAG_LSB +: TAG_W];

    assign hit = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);

    icache_word_select u_word_select (
        .block_i  (data_q[cpu_index]),
        .offset_i (cpu_offset),
        .word_o   (selected_word)
    );

    // Invalid lines read as zero so the output is defined straight out of reset.
    assign cpu_instruction = hit ? selected_word : '0;
    assign cpu_busywait    = cpu_read && ((state_q != IDLE) || !hit);

    assign mem_read    = (state_q == MEM_READ);
    assign mem_address = (state_q == MEM_READ) ? {req_tag_q, req_index_q} : '0;

    always_comb begin
        state_d       = state_q;
        start_fill    = 1'b0;
        capture_block = 1'b0;
        write_line    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_read && !hit) begin
                    state_d    = MEM_READ;
                    start_fill = 1'b1;
                end
            end
            MEM_READ: begin
                if (!mem_busywait) begin
                    state_d       = UPDATE;
                    capture_block = 1'b1;
                end
            end
            UPDATE: begin
                state_d    = IDLE;
                write_line = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // The miss address is latched so the fill completes even if the CPU drops its request.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            req_index_q <= '0;
            req_tag_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_fill) begin
                req_index_q <= cpu_index;
                req_tag_q   <= cpu_tag;
            end
            if (write_line) begin
                valid_q[req_index_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture_block) begin
            line_buf_q <= mem_readdata;
        end
        if (write_line) begin
            data_q[req_index_q] <= line_buf_q;
            tag_q[req_index_q]  <= req_tag_q;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [STAT_W-1:0] hit_count_q, miss_count_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if ((state_q == IDLE) && cpu_read && hit) begin
                hit_count_q <= sat_inc(hit_count_q);
            end
            if (start_fill) begin
                miss_count_q <= sat_inc(miss_count_q);
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a memory responder with fixed latency,
// a behavioural contents model, and a per-cycle compare process.
module tb_instruction_cache;

    localparam int LAT = 3;

    logic         clock;
    logic         reset;
    logic         cpu_read;
    logic [9:0]   cpu_address;
    logic [31:0]  cpu_instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;
`ifdef ICACHE_STATS_EN
    logic [15:0]  hit_count;
    logic [15:0]  miss_count;
`endif

    instruction_cache dut (
        .clock           (clock),
        .reset           (reset),
        .cpu_read        (cpu_read),
        .cpu_address     (cpu_address),
        .cpu_instruction (cpu_instruction),
        .cpu_busywait    (cpu_busywait),
        .mem_read        (mem_read),
        .mem_address     (mem_address),
        .mem_readdata    (mem_readdata),
        .mem_busywait    (mem_busywait)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count       (hit_count),
        .miss_count      (miss_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // Instruction memory contents: a few fixed words, a tagged pattern elsewhere.
    function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] off);
        if (blk == 6'h00) begin
            case (off)
                2'd0: return 32'h00000001;
                2'd1: return 32'h00010000;
                2'd2: return 32'h00020002;
                default: return 32'h02010100;
            endcase
        end
        if (blk == 6'h01 && off == 2'd0) return 32'h0B000100;
        return 32'hC0000000 | (32'(blk) << 8) | 32'(off);
    endfunction

    function automatic logic [127:0] mem_block(input logic [5:0] blk);
        return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
    endfunction

    // Memory responder: busy from the moment read rises for LAT posedges, then data valid.
    int lat_cnt = 0;
    always @(posedge clock) begin
        if (!mem_read) lat_cnt <= 0;
        else if (lat_cnt < LAT) lat_cnt <= lat_cnt + 1;
    end
    assign mem_busywait = mem_read && (lat_cnt < LAT);
    assign mem_readdata = (mem_read && lat_cnt >= LAT) ? mem_block(mem_address) : {4{32'hDEADBEEF}};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural contents model: which block each line holds.
    logic       m_valid [8];
    logic [2:0] m_tag   [8];
    logic [5:0] last_mem_addr;
    int         stall;

    task automatic model_clear();
        for (int i = 0; i < 8; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 3'd0;
        end
    endtask

    task automatic fetch(input logic [9:0] a, output int stall_out);
        logic [2:0] idx;
        logic       exp_hit;
        int         n;
        idx     = a[6:4];
        exp_hit = m_valid[idx] && (m_tag[idx] == a[9:7]);
        @(negedge clock);
        cpu_address = a;
        cpu_read    = 1'b1;
        #1;
        check("busy_same_cycle", 32'(cpu_busywait), 32'(!exp_hit));
        n = 0;
        last_mem_addr = 6'h3F;
        while (cpu_busywait && n < 200) begin
            @(negedge clock);
            #1;
            n++;
            if (n == 1) begin
                check("mem_read_after_miss", 32'(mem_read), 32'd1);
                last_mem_addr = mem_address;
            end
        end
        if (cpu_busywait) begin
            failures++;
            $display("FAIL fetch_timeout: busywait still %b after %0d cycles, required 0", cpu_busywait, n);
        end
        check("stall_cycles", 32'(n), exp_hit ? 32'd0 : 32'(LAT + 3));
        if (exp_hit) check("no_mem_on_hit", 32'(mem_read), 32'd0);
        check("fetch_word", cpu_instruction, mem_word(a[9:4], a[3:2]));
        m_valid[idx] = 1'b1;
        m_tag[idx]   = a[9:7];
        stall_out    = n;
    endtask

    // Per-cycle compare: any unstalled fetch must return the memory word, and an
    // outstanding block read must target the held fetch address.
    always begin
        @(negedge clock);
        #2;
        if (!reset) begin
            if (cpu_read && !cpu_busywait)
                check("cmp_word", cpu_instruction, mem_word(cpu_address[9:4], cpu_address[3:2]));
            if (mem_read)
                check("cmp_mem_addr", 32'(mem_address), 32'(cpu_address[9:4]));
        end
    end

`ifdef ICACHE_STATS_EN
    int exp_hits = 0;
    int exp_miss = 0;
    logic prev_mr = 1'b0;
    always @(posedge clock) begin
        if (reset) exp_hits <= 0;
        else if (cpu_read && !cpu_busywait) exp_hits <= exp_hits + 1;
    end
    always @(negedge clock) begin
        if (reset) exp_miss <= 0;
        else if (mem_read && !prev_mr) exp_miss <= exp_miss + 1;
        prev_mr <= mem_read;
    end
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        reset       = 1'b1;
        cpu_read    = 1'b0;
        cpu_address = 10'h000;
        repeat (3) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_mem_read", 32'(mem_read), 32'd0);
        check("rst_mem_addr", 32'(mem_address), 32'd0);
        check("rst_busywait", 32'(cpu_busywait), 32'd0);
        check("rst_instr", cpu_instruction, 32'd0);
        reset = 1'b0;

        // Cold miss on line 0, then hits on the rest of the block.
        fetch(10'h000, stall);
        check("cold_miss_addr", 32'(last_mem_addr), 32'h00);
        check("cold_miss_stall", 32'(stall), 32'd6);
        check("cold_miss_word", cpu_instruction, 32'h00000001);
        fetch(10'h004, stall);
        check("hit_04", cpu_instruction, 32'h00010000);
        check("hit_04_stall", 32'(stall), 32'd0);
        fetch(10'h008, stall);
        check("hit_08", cpu_instruction, 32'h00020002);
        fetch(10'h00C, stall);
        check("hit_0C", cpu_instruction, 32'h02010100);
        check("hit_0C_no_mem", 32'(mem_read), 32'd0);

        // Conflict: same index, different tag replaces the line.
        fetch(10'h080, stall);
        check("conflict_addr", 32'(last_mem_addr), 32'h08);
        check("conflict_word", cpu_instruction, 32'hC0000800);
        fetch(10'h000, stall);
        check("refetch_misses", 32'(stall), 32'd6);

        // Different index leaves line 0 alone.
        fetch(10'h010, stall);
        check("idx1_addr", 32'(last_mem_addr), 32'h01);
        check("idx1_word", cpu_instruction, 32'h0B000100);
        fetch(10'h000, stall);
        check("line0_kept", 32'(stall), 32'd0);

        // Request dropped mid-fill: the line still becomes valid.
        @(negedge clock);
        cpu_address = 10'h030;
        cpu_read    = 1'b1;
        #1;
        check("drop_busy", 32'(cpu_busywait), 32'd1);
        @(negedge clock);
        @(negedge clock);
        cpu_read = 1'b0;
        #1;
        check("drop_no_busy", 32'(cpu_busywait), 32'd0);
        repeat (8) @(negedge clock);
        m_valid[3] = 1'b1;
        m_tag[3]   = 3'd0;
        fetch(10'h030, stall);
        check("drop_line_valid", 32'(stall), 32'd0);

        // Reset in the middle of a fill.
        @(negedge clock);
        cpu_address = 10'h020;
        cpu_read    = 1'b1;
        @(negedge clock);
        #1;
        check("pre_rst_mem_read", 32'(mem_read), 32'd1);
        @(negedge clock);
        reset    = 1'b1;
        cpu_read = 1'b0;
        @(negedge clock);
        #1;
        check("midfill_rst_mem_read", 32'(mem_read), 32'd0);
        check("midfill_rst_busy", 32'(cpu_busywait), 32'd0);
        check("midfill_rst_addr", 32'(mem_address), 32'd0);
        reset = 1'b0;
        model_clear();
        fetch(10'h000, stall);
        check("post_rst_miss", 32'(stall), 32'd6);
        fetch(10'h004, stall);
        check("post_rst_hit", cpu_instruction, 32'h00010000);

`ifdef ICACHE_STATS_EN
        @(negedge clock);
        cpu_read = 1'b0;
        @(negedge clock);
        #1;
        check("stat_hits", 32'(hit_count), 32'(exp_hits));
        check("stat_miss", 32'(miss_count), 32'(exp_miss));
        check("stat_miss_lit", 32'(miss_count), 32'd1);
`endif

        @(negedge clock);
        cpu_read = 1'b0;
        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
